// File: rtl/ip_mapperram_pkg.sv
// ip_mapperram_pkg: shared FSM encoding, segment reset values and I/O base default.
package ip_mapperram_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;
  localparam logic [7:0] IO_BASE_DEF = 8'hFC;
  function automatic logic [7:0] seg_rst(input int n);
    return 8'(3 - n);
  endfunction
endpackage

// File: rtl/ip_mapperram_if.sv
// ip_mapperram_if: MSX-50BUS side of the memory mapper.
interface ip_mapperram_if;
  logic [15:0] bus_address;
  logic        bus_io_cs;
  logic        bus_memory_cs;
  logic        bus_read_ready;
  logic [7:0]  bus_read_data;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_io;
  logic        bus_memory;
  modport master (
    output bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    input  bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data
  );
  modport slave (
    input  bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory,
    output bus_io_cs, bus_memory_cs, bus_read_ready, bus_read_data
  );
endinterface

// File: rtl/ip_mapperram_segs.sv
// ip_mapperram_segs: four page segment registers with page lookup and I/O readback.
module ip_mapperram_segs import ip_mapperram_pkg::*; #(
  parameter int SEG_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [1:0]          wsel,
  input  logic [7:0]          wdata,
  input  logic [1:0]          msel,
  output logic [SEG_BITS-1:0] seg_mem,
  input  logic [1:0]          rsel,
  output logic [7:0]          rd_data
);
  logic [SEG_BITS-1:0] seg_q [4];
  logic [SEG_BITS-1:0] seg_d [4];
  always_comb begin
    seg_d = seg_q;
    if (we) seg_d[wsel] = wdata[SEG_BITS-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < 4; i++) seg_q[i] <= SEG_BITS'(seg_rst(i));
    else seg_q <= seg_d;
  end
  assign seg_mem = seg_q[msel];
  // unimplemented high bits read back as ones
  always_comb begin
    rd_data = 8'hFF;
    rd_data[SEG_BITS-1:0] = seg_q[rsel];
  end
endmodule

// File: rtl/ip_mapperram_param.sv
// ip_mapperram_param: MSX memory mapper bridging the 50-pin bus to a paged RAM.
module ip_mapperram_param import ip_mapperram_pkg::*; #(
  parameter int         SEG_BITS = 8,
  parameter logic [7:0] IO_BASE  = IO_BASE_DEF,
  parameter int         READBACK = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ip_mapperram_if.slave        mbus,
  output logic                 rd,
  output logic                 wr,
  input  logic                 busy,
  output logic [SEG_BITS+13:0] address,
  output logic [7:0]           wdata,
  input  logic [7:0]           rdata,
  input  logic                 rdata_en
);
  localparam int RAM_AW = SEG_BITS + 14;
  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d, rdata_q, rdata_d, seg_rb;
  logic                is_wr_q, is_wr_d, rdy_q, rdy_d, io_prev_q, io_prev_d;
  logic [SEG_BITS-1:0] seg_mem;
  logic                io_cs, io_rd, mem_req;
  assign io_cs   = mbus.bus_address[7:2] == IO_BASE[7:2];
  assign io_rd   = (READBACK != 0) && mbus.bus_io && mbus.bus_read && io_cs;
  assign mem_req = mbus.bus_memory && (mbus.bus_read || mbus.bus_write);
  ip_mapperram_segs #(.SEG_BITS(SEG_BITS)) u_segs (
    .clk     (clk),
    .reset   (reset),
    .we      (mbus.bus_io && mbus.bus_write && io_cs),
    .wsel    (mbus.bus_address[1:0]),
    .wdata   (mbus.bus_write_data),
    .msel    (mbus.bus_address[15:14]),
    .seg_mem (seg_mem),
    .rsel    (mbus.bus_address[1:0]),
    .rd_data (seg_rb)
  );
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    rdata_d   = rdata_q;
    rdy_d     = 1'b0;
    io_prev_d = io_rd;
    // readback answers once per strobe assertion
    if (io_rd && !io_prev_q) begin
      rdy_d   = 1'b1;
      rdata_d = seg_rb;
    end
    case (state_q)
      IDLE: if (mem_req) begin
        state_d = REQ;
        addr_d  = {seg_mem, mbus.bus_address[13:0]};
        wdata_d = mbus.bus_write_data;
        is_wr_d = !mbus.bus_read;
      end
      REQ: if (!busy) state_d = is_wr_q ? DONE : WAIT_RD;
      WAIT_RD: if (rdata_en) begin
        state_d = DONE;
        rdata_d = rdata;
        rdy_d   = 1'b1;
      end
      DONE: if (!mem_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      rdata_q   <= 8'hFF;
      rdy_q     <= 1'b0;
      io_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      rdata_q   <= rdata_d;
      rdy_q     <= rdy_d;
      io_prev_q <= io_prev_d;
    end
  end
  assign rd                  = state_q == REQ && !is_wr_q;
  assign wr                  = state_q == REQ && is_wr_q;
  assign address             = addr_q;
  assign wdata               = wdata_q;
  assign mbus.bus_io_cs      = io_cs;
  assign mbus.bus_memory_cs  = 1'b1;
  assign mbus.bus_read_ready = rdy_q;
  assign mbus.bus_read_data  = rdata_q;
endmodule

// File: tb/tb_ip_mapperram_param.sv
// tb_ip_mapperram_param: directed checks on default, 5-bit and no-readback mapper instances.
module tb_ip_mapperram_param;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] a = '0;
  logic [7:0] wd = '0, rdata = '0;
  logic rd_s = 0, wr_s = 0, io = 0, mem = 0, busy = 0, rdata_en = 0;
  logic rd0, wr0, rd1, wr1, rd2, wr2;
  logic [21:0] addr0, addr2;
  logic [18:0] addr1;
  logic [7:0] wd0, wd1, wd2;
  int n_cmp = 0, n_bad = 0;
  int acc0 = 0, rdy0 = 0, rdy1 = 0, rdy2 = 0;
  int s_acc, s0, s1, s2, nw;
  always #5 clk = ~clk;
  ip_mapperram_if ifs[3] ();
  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign ifs[g].bus_address    = a;
    assign ifs[g].bus_write_data = wd;
    assign ifs[g].bus_read       = rd_s;
    assign ifs[g].bus_write      = wr_s;
    assign ifs[g].bus_io         = io;
    assign ifs[g].bus_memory     = mem;
  end
  ip_mapperram_param dut0 (.clk(clk), .reset(reset), .mbus(ifs[0]), .rd(rd0), .wr(wr0), .busy(busy),
    .address(addr0), .wdata(wd0), .rdata(rdata), .rdata_en(rdata_en));
  ip_mapperram_param #(.SEG_BITS(5)) dut1 (.clk(clk), .reset(reset), .mbus(ifs[1]), .rd(rd1), .wr(wr1),
    .busy(busy), .address(addr1), .wdata(wd1), .rdata(rdata), .rdata_en(rdata_en));
  ip_mapperram_param #(.READBACK(0)) dut2 (.clk(clk), .reset(reset), .mbus(ifs[2]), .rd(rd2), .wr(wr2),
    .busy(busy), .address(addr2), .wdata(wd2), .rdata(rdata), .rdata_en(rdata_en));
  always @(negedge clk) begin
    if ((rd0 || wr0) && !busy) acc0++;
    if (ifs[0].bus_read_ready) rdy0++;
    if (ifs[1].bus_read_ready) rdy1++;
    if (ifs[2].bus_read_ready) rdy2++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick;
    chk("rst_rd", rd0, 0);
    chk("rst_wr", wr0, 0);
    chk("rst_rdy", ifs[0].bus_read_ready, 0);
    chk("rst_rdata", ifs[0].bus_read_data, 8'hFF);
    chk("rst_addr", addr0, 0);
    chk("rst_wdata", wd0, 0);
    chk("mem_cs", ifs[0].bus_memory_cs, 1);
    chk("io_cs_00", ifs[0].bus_io_cs, 0);
    reset = 0; tick;
    io = 1; rd_s = 1; a = 16'h00FE; #1;
    chk("io_cs_fe", ifs[0].bus_io_cs, 1);
    tick;
    chk("rb_seg2", ifs[0].bus_read_data, 8'h01);
    chk("rb5_seg2", ifs[1].bus_read_data, 8'hE1);
    chk("rb_off_rdy", ifs[2].bus_read_ready, 0);
    io = 0; rd_s = 0; tick;
    s_acc = acc0; s0 = rdy0;
    mem = 1; rd_s = 1; a = 16'h8000; tick;
    chk("rd_p2", rd0, 1);
    chk("addr_p2", addr0, 22'h004000);
    tick;
    chk("rd_drop", rd0, 0);
    rdata = 8'h5A; rdata_en = 1; tick;
    chk("mrd_rdy", ifs[0].bus_read_ready, 1);
    chk("mrd_data", ifs[0].bus_read_data, 8'h5A);
    rdata_en = 0;
    for (int i = 0; i < 20; i++) begin
      rdata = 8'h11; rdata_en = (i == 5); tick;
    end
    rdata_en = 0;
    chk("hold_acc", acc0 - s_acc, 1);
    chk("hold_rdy", rdy0 - s0, 1);
    chk("hold_data", ifs[0].bus_read_data, 8'h5A);
    mem = 0; rd_s = 0; tick; tick;
    io = 1; wr_s = 1; a = 16'h00FE; wd = 8'h07; tick;
    io = 0; wr_s = 0;
    s_acc = acc0; nw = 0;
    mem = 1; wr_s = 1; a = 16'hA123; wd = 8'h3C; busy = 1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (wr0) nw++;
      if (i == 2) wd = 8'h55;
      if (i == 4) begin
        chk("wr_addr", addr0, 22'h01E123);
        chk("wr_wdata", wd0, 8'h3C);
        busy = 0;
      end
    end
    chk("wr_cycles", nw, 4);
    chk("wr_acc", acc0 - s_acc, 1);
    mem = 0; wr_s = 0; tick; tick;
    io = 1; wr_s = 1; a = 16'h00FF; wd = 8'hFF; tick;
    s0 = rdy0; s1 = rdy1; s2 = rdy2;
    wr_s = 0; rd_s = 1; tick;
    chk("io5_rdy", ifs[1].bus_read_ready, 1);
    chk("io5_ff", ifs[1].bus_read_data, 8'hFF);
    repeat (3) tick;
    chk("io_norepeat", rdy0 - s0, 1);
    chk("io5_norepeat", rdy1 - s1, 1);
    chk("rb_off_cnt", rdy2 - s2, 0);
    rd_s = 0; wr_s = 1; wd = 8'h02; tick;
    wr_s = 0; rd_s = 1; tick;
    chk("io5_e2", ifs[1].bus_read_data, 8'hE2);
    chk("io8_02", ifs[0].bus_read_data, 8'h02);
    io = 0; rd_s = 0; tick;
    io = 1; rd_s = 1; a = 16'h00F8; #1;
    chk("io_cs_f8", ifs[0].bus_io_cs, 0);
    s0 = rdy0; tick; tick;
    chk("f8_rdy", rdy0 - s0, 0);
    io = 0; rd_s = 0; tick;
    mem = 1; rd_s = 1; a = 16'h0000; busy = 1; tick;
    chk("rst_req_rd", rd0, 1);
    reset = 1; tick;
    chk("rst_mid_rd", rd0, 0);
    reset = 0; mem = 0; rd_s = 0; busy = 0; tick;
    s0 = rdy0;
    rdata = 8'h77; rdata_en = 1; tick;
    rdata_en = 0; tick;
    chk("stale_en_rdy", rdy0 - s0, 0);
    chk("stale_en_data", ifs[0].bus_read_data, 8'hFF);
    io = 1; rd_s = 1; a = 16'h00FE; tick;
    chk("rst2_seg2", ifs[0].bus_read_data, 8'h01);
    io = 0; rd_s = 0; tick;
    mem = 1; rd_s = 1; a = 16'hC005; tick;
    chk("rd_p3", rd0, 1);
    chk("addr_p3", addr0, 22'h000005);
    tick;
    rdata = 8'hA5; rdata_en = 1; tick;
    chk("p3_data", ifs[0].bus_read_data, 8'hA5);
    rdata_en = 0; mem = 0; rd_s = 0; tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
